// File: rtl/uart_trans_secded_gen_pkg.sv
// Shared types and helpers for the SEC-DED UART transmitter.
// FSM states, status bit positions, parity codes and the (8,4) encoder.
package uart_trans_secded_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int ST_FULL  = 2;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 0;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // byte = {d3,d2,d1,p4,d0,p2,p1,p0}, p0 is overall parity
    function automatic logic [7:0] secded_enc84(input logic [3:0] d);
        logic p1, p2, p4, p0;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        p0 = ^{d[3], d[2], d[1], p4, d[0], p2, p1};
        return {d[3], d[2], d[1], p4, d[0], p2, p1, p0};
    endfunction

endpackage

// File: rtl/uart_trans_secded_gen_fifo.sv
// Synchronous word FIFO feeding the transmitter.
// Ports: clk, reset_n, wr/din push, rd/dout pop (show-ahead), full, empty.
module uart_trans_secded_gen_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // a full FIFO refuses the push even when a pop happens alongside
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_trans_secded_gen.sv
// UART TX: FIFO-buffered words sent as SEC-DED nibble frames or raw bytes.
// Ports: trans/bus_data_in push, tx line, status {full,empty,busy}, s_tick.
module uart_trans_secded_gen
    import uart_trans_secded_gen_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int SIZE_FIFO   = 16,
    parameter int SYS_FREQ    = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int SAMPLE      = 16,
    parameter int ECC_EN      = 1,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trans,
    input  logic [DATA_SIZE-1:0] bus_data_in,
    output logic                 tx,
    output logic [2:0]           TX_status_register,
    output logic                 wait_request,
    output logic                 s_tick,
    output logic                 waiting_nibble
);

    localparam int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE);
    localparam int FPW = (ECC_EN != 0) ? DATA_SIZE / 4 : DATA_SIZE / 8;
    localparam int FW  = (FPW > 1) ? $clog2(FPW) : 1;
    localparam int CW  = $clog2(BAUD_DVSR);
    localparam int TW  = $clog2(SAMPLE);

    localparam logic [CW-1:0] CNT_TOP   = CW'(BAUD_DVSR - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(BAUD_DVSR - 2);
    localparam logic [TW-1:0] TICK_TOP  = TW'(SAMPLE - 1);
    localparam logic [FW-1:0] FRAME_TOP = FW'(FPW - 1);
    localparam logic          STOP_TOP  = 1'(STOP_BITS - 1);

    state_t               state, nstate;
    logic [CW-1:0]        baud_cnt;
    logic [TW-1:0]        tcnt, ntcnt;
    logic [2:0]           bit_idx, nbit;
    logic                 stop_idx, nstop;
    logic [FW-1:0]        frame_idx, nframe;
    logic [DATA_SIZE-1:0] word;
    logic [DATA_SIZE-1:0] fifo_dout;
    logic                 fifo_full, fifo_empty, fifo_rd;
    logic                 pre_tick, bit_end, in_frame;
    logic                 frame_last, stop_last;
    logic [3:0]           nib;
    logic [7:0]           raw, fbyte;
    logic                 par_bit;

    uart_trans_secded_gen_fifo #(
        .WIDTH(DATA_SIZE),
        .DEPTH(SIZE_FIFO)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .wr     (trans),
        .rd     (fifo_rd),
        .din    (bus_data_in),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) baud_cnt <= '0;
        else if (baud_cnt == CNT_TOP) baud_cnt <= '0;
        else baud_cnt <= baud_cnt + 1'b1;
    end

    assign s_tick   = (baud_cnt == CNT_TOP);
    // one cycle ahead of s_tick: lets LOAD sit on the tick cycle so
    // the next start bit lines up with the bit grid
    assign pre_tick = (baud_cnt == CNT_PRE);
    assign bit_end  = s_tick && (tcnt == TICK_TOP);

    assign in_frame   = (state == START) || (state == DATA) ||
                        (state == PARITY) || (state == STOP);
    assign frame_last = (frame_idx == FRAME_TOP);
    assign stop_last  = (stop_idx == STOP_TOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            frame_idx <= '0;
            word      <= '0;
        end else begin
            state     <= nstate;
            tcnt      <= ntcnt;
            bit_idx   <= nbit;
            stop_idx  <= nstop;
            frame_idx <= nframe;
            if (fifo_rd) word <= fifo_dout;
        end
    end

    always_comb begin
        nstate  = state;
        ntcnt   = tcnt;
        nbit    = bit_idx;
        nstop   = stop_idx;
        nframe  = frame_idx;
        fifo_rd = 1'b0;
        if (in_frame && s_tick) ntcnt = bit_end ? '0 : tcnt + 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && pre_tick) nstate = LOAD;
            end
            LOAD: begin
                fifo_rd = 1'b1;
                ntcnt   = '0;
                nframe  = '0;
                nstate  = START;
            end
            START: begin
                if (bit_end) begin
                    nbit   = '0;
                    nstate = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    nbit = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        nstop  = 1'b0;
                        nstate = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    nstop  = 1'b0;
                    nstate = STOP;
                end
            end
            STOP: begin
                if (tcnt == TICK_TOP && stop_last && frame_last) begin
                    // end of word: chain straight into the next one
                    if (!fifo_empty && pre_tick) nstate = LOAD;
                    else if (s_tick) nstate = IDLE;
                end else if (bit_end) begin
                    if (stop_last) begin
                        nframe = frame_idx + 1'b1;
                        nstate = START;
                    end else begin
                        nstop = 1'b1;
                    end
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        nib     = 4'(word >> {frame_idx, 2'b00});
        raw     = 8'(word >> {frame_idx, 3'b000});
        fbyte   = (ECC_EN != 0) ? secded_enc84(nib) : raw;
        par_bit = (^fbyte) ^ (PARITY_MODE == PARITY_ODD);
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = fbyte[bit_idx];
            PARITY:  tx = par_bit;
            default: tx = 1'b1;
        endcase
    end

    assign waiting_nibble     = in_frame && !frame_last;
    assign wait_request       = fifo_full;
    assign TX_status_register = {fifo_full, fifo_empty, state != IDLE};

endmodule
